// File: rtl/denormalize.sv
// -----------------------------------------------------------------------------
// denormalize
//
// Purpose:
//   Streaming fp32 -> accumulator-triplet converter, the inverse of the output
//   normalizer. Each accepted word becomes {signo, expo, addo} with
//       value = (-1)^signo * addo * 2^(expo - 268)
//   which is the convention shared with fma and normalizer. The triplet feeds
//   signi/expi/addi of the first core in the chain so partial sums can be
//   reloaded before accumulation resumes.
//
//   Two-stage pipeline (decode register, output register) with valid/ready on
//   both sides. Full throughput of one word per cycle, capacity of two words
//   when the output is stalled.
//
// Conversion by exponent field E:
//   1..254 : signo = s, expo = E + 118, addo = {8'h00, 1'b1, m[22:0]} (exact)
//   0      : zero / denormal flushed to 0/0/0
//   255    : Inf/NaN saturates to expo = 372, addo = 32'h00FF_FFFF, sets ovf
//
// Build option:
//   DENORMALIZE_BF16_EN  when defined, in_data[15:0] is taken as bfloat16
//                        (bit15 sign, 14:7 E, 6:0 m7) and m = {m7, 16'h0000};
//                        in_data[31:16] is ignored. Undefined: full fp32.
//
// Ports:
//   clk        clock, all state on the rising edge
//   init       synchronous active-high reset, overrides all other inputs
//   in_valid   input word valid
//   in_ready   block can accept a word this cycle (combinational)
//   in_data    fp32 word (or bf16 in the low half, see above)
//   in_last    end-of-vector tag travelling with the word
//   out_valid  triplet valid
//   out_ready  downstream accepts the triplet
//   signo      sign
//   expo       accumulator exponent (signed 10 bit)
//   addo       accumulator mantissa (signed 32 bit, always >= 0)
//   out_last   tag of the current output
//   ovf        sticky flag: an Inf/NaN word has been accepted since init
//   cnt        words accepted since init, modulo 2^CNT_W
// -----------------------------------------------------------------------------
module denormalize #(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                init,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                signo,
    output logic signed [9:0]   expo,
    output logic signed [31:0]  addo,
    output logic                out_last,
    output logic                ovf,
    output logic [CNT_W-1:0]    cnt
);

    // Exponent bias between the fp32 field and the accumulator convention:
    // 2^(E-127) * 1.m = 2^(E+118-268) * {1,m} with the leading one at bit 23.
    localparam logic [9:0]  EXP_OFFSET = 10'd118;
    localparam logic [9:0]  EXP_SAT    = 10'd372;
    localparam logic [31:0] ADDO_SAT   = 32'h00FF_FFFF;

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic        w_sign;
    logic [7:0]  w_exp;
    logic [22:0] w_man;

`ifdef DENORMALIZE_BF16_EN
    // Upper half is deliberately ignored in bfloat16 mode.
    logic w_unused_hi;
    assign w_unused_hi = ^in_data[31:16];
    assign w_sign      = in_data[15];
    assign w_exp       = in_data[14:7];
    assign w_man       = {in_data[6:0], 16'h0000};
`else
    assign w_sign      = in_data[31];
    assign w_exp       = in_data[30:23];
    assign w_man       = in_data[22:0];
`endif

    // ------------------------------------------------------------------
    // Decode into the accumulator triplet
    // ------------------------------------------------------------------
    logic        w_is_zero;
    logic        w_is_inf;
    logic        w_d_sign;
    logic [9:0]  w_d_expo;
    logic [31:0] w_d_addo;

    assign w_is_zero = (w_exp == 8'h00);
    assign w_is_inf  = (w_exp == 8'hFF);

    always_comb begin
        w_d_sign = w_sign;
        w_d_expo = {2'b00, w_exp} + EXP_OFFSET;
        w_d_addo = {8'h00, 1'b1, w_man};
        if (w_is_zero) begin
            // Denormals flush to zero; sign is dropped so -0 and +0 agree.
            w_d_sign = 1'b0;
            w_d_expo = 10'd0;
            w_d_addo = 32'd0;
        end else if (w_is_inf) begin
            // Saturate to the largest representable magnitude, keep the sign.
            w_d_expo = EXP_SAT;
            w_d_addo = ADDO_SAT;
        end
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_v1;
    logic r_v2;
    logic w_adv2;
    logic w_accept;

    // Stage 2 may load whenever it is empty or its content is being taken;
    // stage 1 may load whenever it is empty or it moves into stage 2.
    assign w_adv2   = ~r_v2 | out_ready;
    assign in_ready = ~r_v1 | w_adv2;
    assign w_accept = in_valid & in_ready;

    // ------------------------------------------------------------------
    // Stage 1: decoded word
    // ------------------------------------------------------------------
    logic        r_s1_sign;
    logic [9:0]  r_s1_expo;
    logic [31:0] r_s1_addo;
    logic        r_s1_last;

    // ------------------------------------------------------------------
    // Stage 2: output register and status
    // ------------------------------------------------------------------
    logic             r_signo;
    logic [9:0]       r_expo;
    logic [31:0]      r_addo;
    logic             r_last;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (init) begin
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_s1_sign <= 1'b0;
            r_s1_expo <= 10'd0;
            r_s1_addo <= 32'd0;
            r_s1_last <= 1'b0;
            r_signo   <= 1'b0;
            r_expo    <= 10'd0;
            r_addo    <= 32'd0;
            r_last    <= 1'b0;
            r_ovf     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (w_accept) begin
                r_v1      <= 1'b1;
                r_s1_sign <= w_d_sign;
                r_s1_expo <= w_d_expo;
                r_s1_addo <= w_d_addo;
                r_s1_last <= in_last;
                r_cnt     <= r_cnt + CNT_W'(1);
                if (w_is_inf) begin
                    r_ovf <= 1'b1;
                end
            end else if (w_adv2) begin
                r_v1 <= 1'b0;
            end

            // Output register only moves when it is free or being drained,
            // so a stalled triplet stays stable.
            if (w_adv2) begin
                r_v2    <= r_v1;
                r_signo <= r_s1_sign;
                r_expo  <= r_s1_expo;
                r_addo  <= r_s1_addo;
                r_last  <= r_s1_last;
            end
        end
    end

    assign out_valid = r_v2;
    assign signo     = r_signo;
    assign expo      = r_expo;
    assign addo      = r_addo;
    assign out_last  = r_last;
    assign ovf       = r_ovf;
    assign cnt       = r_cnt;

endmodule
